// File: rtl/reg_file_mp.sv
`default_nettype none
// =====================================================================
// Module  : reg_file_mp
// Brief   : Multi-port register file, NUM_RD combinational read ports and
//           NUM_WR write ports, zeroed by a sweep after reset. Address 0
//           always reads zero. Optional same-cycle write-to-read
//           forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
// Revision: 1.0  initial release
// =====================================================================
module reg_file_mp #(
   parameter int D_WIDTH       = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int NUM_RD        = 2,
   parameter int NUM_WR        = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wa,
   input  logic [NUM_WR*D_WIDTH-1:0]       wd,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] ra,
   output logic [NUM_RD*D_WIDTH-1:0]       rd,
   output logic                            ready,
   output logic                            wr_conflict
);

   localparam int                       c_depth     = 2**ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] c_last_addr = ADDRESS_WIDTH'(c_depth - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
   logic                     wr_conflict_q, wr_conflict_d;
   logic                     clr_we;
   logic                     wr_allow;
   logic [D_WIDTH-1:0]       mem_q [c_depth];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_CLEAR;
         ptr_q         <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      clr_we   = 1'b0;
      wr_allow = 1'b0;
      case (state_q)
         S_CLEAR: begin
            clr_we = !rst;
            ptr_d  = ptr_q + ADDRESS_WIDTH'(1);
            if (ptr_q == c_last_addr) begin
               state_d = S_READY;
            end
         end
         S_READY: begin
            wr_allow = !rst;
         end
         default: begin
            state_d = S_CLEAR;
         end
      endcase
   end

   // Ports are applied in ascending order, so port 1 wins a same-address collision.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_allow) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wa[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] != '0)) begin
               mem_q[wa[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= wd[k*D_WIDTH +: D_WIDTH];
            end
         end
      end
   end

   if (NUM_WR == 2) begin : g_conflict
      assign wr_conflict_d = wr_allow && (&wr_en)
                          && (wa[0 +: ADDRESS_WIDTH] == wa[ADDRESS_WIDTH +: ADDRESS_WIDTH])
                          && (wa[0 +: ADDRESS_WIDTH] != '0);
   end else begin : g_no_conflict
      assign wr_conflict_d = 1'b0;
   end

   for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDRESS_WIDTH-1:0] lane_addr;
      logic [D_WIDTH-1:0]       lane_data;

      always_comb begin
         lane_addr = ra[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         lane_data = mem_q[lane_addr];
`ifdef REG_FILE_MP_BYPASS_EN
         if (wr_allow) begin
            for (int k = 0; k < NUM_WR; k++) begin
               if (wr_en[k] && (wa[k*ADDRESS_WIDTH +: ADDRESS_WIDTH] == lane_addr)) begin
                  lane_data = wd[k*D_WIDTH +: D_WIDTH];
               end
            end
         end
`endif
         // Entries are not trusted until the sweep finishes; address 0 is hard zero.
         if ((state_q != S_READY) || (lane_addr == '0)) begin
            lane_data = '0;
         end
      end

      assign rd[j*D_WIDTH +: D_WIDTH] = lane_data;
   end

   assign ready       = (state_q == S_READY);
   assign wr_conflict = wr_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// =====================================================================
// Module  : tb_reg_file_mp
// Brief   : Self-checking bench for reg_file_mp (3 read, 2 write ports),
//           directed steps plus random traffic against an array model.
//           Forwarding expectations follow REG_FILE_MP_BYPASS_EN.
// Revision: 1.0  initial release
// =====================================================================
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;
   localparam int NW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NW-1:0]   wr_en;
   logic [NW*AW-1:0] wa;
   logic [NW*DW-1:0] wd;
   logic [NR*AW-1:0] ra;
   logic [NR*DW-1:0] rd;
   logic            ready;
   logic            wr_conflict;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents are only meaningful once the sweep is done.
   logic [DW-1:0] m_mem [32];
   bit            m_ready = 1'b0;
   int            m_cnt   = 0;
   bit            m_conf  = 1'b0;

   reg_file_mp #(
      .D_WIDTH      (DW),
      .ADDRESS_WIDTH(AW),
      .NUM_RD       (NR),
      .NUM_WR       (NW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wa         (wa),
      .wd         (wd),
      .ra         (ra),
      .rd         (rd),
      .ready      (ready),
      .wr_conflict(wr_conflict)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
      if (!m_ready || a == '0) return '0;
`ifdef REG_FILE_MP_BYPASS_EN
      if (!rst && wr_en[1] && wa[AW +: AW] == a) return wd[DW +: DW];
      if (!rst && wr_en[0] && wa[0 +: AW] == a) return wd[0 +: DW];
`endif
      return m_mem[a];
   endfunction

   task automatic check_lanes(input string tag);
      for (int j = 0; j < NR; j++) begin
         check($sformatf("%s_lane%0d", tag, j), rd[j*DW +: DW], exp_rd(ra[j*AW +: AW]));
      end
   endtask

   // Advance the model with the inputs the DUT is about to sample, then clock.
   task automatic tick();
      logic [AW-1:0] a0, a1;
      a0 = wa[0 +: AW];
      a1 = wa[AW +: AW];
      if (rst) begin
         m_ready = 1'b0;
         m_cnt   = 0;
         m_conf  = 1'b0;
      end else if (!m_ready) begin
         m_cnt++;
         m_conf = 1'b0;
         if (m_cnt == 32) begin
            m_ready = 1'b1;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end else begin
         m_conf = (wr_en == 2'b11) && (a0 == a1) && (a0 != '0);
         if (wr_en[0] && a0 != '0) m_mem[a0] = wd[0 +: DW];
         if (wr_en[1] && a1 != '0) m_mem[a1] = wd[DW +: DW];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      ra = {a2, a1, a0};
   endtask

   initial begin
      int n;
      rst   = 1'b1;
      wr_en = '0;
      wa    = '0;
      wd    = '0;
      ra    = '0;

      // Reset and clear sweep length.
      tick();
      tick();
      check("rst_ready", DW'(ready), '0);
      check("rst_conf", DW'(wr_conflict), '0);
      check_lanes("rst_rd");
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check($sformatf("sweep_ready_%0d", i), DW'(ready), '0);
         wr_en = 2'($urandom_range(0, 3));
         wa    = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
         wd    = {$urandom, $urandom};
         set_ra(5'($urandom), 5'($urandom), 5'($urandom));
         #1;
         check_lanes("sweep_rd");
         tick();
      end
      check("ready_up", DW'(ready), 32'd1);
      wr_en = '0;
      for (int a = 0; a < 32; a++) begin
         set_ra(5'(a), 5'(a), 5'(a));
         #1;
         check($sformatf("zero_a%0d", a), rd[0 +: DW], '0);
      end

      // Port 0 to address 5, port 1 to address 0 (discarded).
      wr_en = 2'b11;
      wa    = {5'd0, 5'd5};
      wd    = {32'h12345678, 32'hDEADBEEF};
      set_ra(5'd5, 5'd0, 5'd5);
      #1;
      check_lanes("w5_same");
      tick();
      wr_en = '0;
      #1;
      check("w5_rd", rd[0 +: DW], 32'hDEADBEEF);
      check("w0_rd", rd[DW +: DW], 32'h0);
      check("w5_conf", DW'(wr_conflict), '0);

      // Same-address dual write: port 1 wins, conflict pulses once.
      wr_en = 2'b11;
      wa    = {5'd7, 5'd7};
      wd    = {32'h22222222, 32'h11111111};
      set_ra(5'd7, 5'd7, 5'd7);
      #1;
      check_lanes("w7_same");
      tick();
      wr_en = '0;
      #1;
      check("w7_rd", rd[0 +: DW], 32'h22222222);
      check("w7_conf", DW'(wr_conflict), 32'd1);
      tick();
      check("w7_conf_clr", DW'(wr_conflict), '0);

      // Same-cycle visibility on lane 2.
      wr_en = 2'b01;
      wa    = {5'd0, 5'd9};
      wd    = {32'h0, 32'hCAFEF00D};
      set_ra(5'd0, 5'd5, 5'd9);
`ifdef REG_FILE_MP_BYPASS_EN
      #1;
      check("w9_same", rd[2*DW +: DW], 32'hCAFEF00D);
`else
      #1;
      check("w9_same", rd[2*DW +: DW], 32'h0);
`endif
      tick();
      wr_en = '0;
      #1;
      check("w9_next", rd[2*DW +: DW], 32'hCAFEF00D);

      // All lanes on one entry, then mixed with address 31.
      wr_en = 2'b10;
      wa    = {5'd31, 5'd0};
      wd    = {32'hFFFFFFFF, 32'h0};
      tick();
      wr_en = '0;
      set_ra(5'd5, 5'd5, 5'd5);
      #1;
      for (int j = 0; j < NR; j++) check($sformatf("same5_l%0d", j), rd[j*DW +: DW], 32'hDEADBEEF);
      set_ra(5'd31, 5'd5, 5'd31);
      #1;
      check("mix_l0", rd[0 +: DW], 32'hFFFFFFFF);
      check("mix_l1", rd[DW +: DW], 32'hDEADBEEF);
      check("mix_l2", rd[2*DW +: DW], 32'hFFFFFFFF);

      // Random traffic on a narrow address range to provoke collisions.
      for (int i = 0; i < 300; i++) begin
         wr_en = 2'($urandom_range(0, 3));
         wa    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         wd    = {$urandom, $urandom};
         set_ra(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
         #1;
         check_lanes("rnd_rd");
         tick();
         check("rnd_conf", DW'(wr_conflict), DW'(m_conf));
         check("rnd_ready", DW'(ready), DW'(m_ready));
      end

      // Reset in the middle of a sweep restarts it; writes stay ignored.
      wr_en = 2'b01;
      wa    = {5'd0, 5'd3};
      wd    = {32'h0, 32'hA5A5A5A5};
      tick();
      wr_en = '0;
      set_ra(5'd3, 5'd0, 5'd0);
      #1;
      check("pre_a3", rd[0 +: DW], 32'hA5A5A5A5);
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      wr_en = 2'b01;
      wd    = {32'h0, 32'h5A5A5A5A};
      for (int i = 0; i < 10; i++) tick();
      check("mid_ready", DW'(ready), '0);
      rst = 1'b1;
      tick();
      check("mid_rst_ready", DW'(ready), '0);
      rst = 1'b0;
      n   = 0;
      while (!ready && n < 40) begin
         tick();
         n++;
      end
      check("resweep_len", DW'(n), 32'd32);
      check("resweep_model", DW'(ready), DW'(m_ready));
      wr_en = '0;
      #1;
      check("resweep_a3", rd[0 +: DW], 32'h0);
      check_lanes("resweep_rd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter D_WIDTH, default 32: register data width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 5: register address width; DEPTH = 2**ADDRESS_WIDTH.
REQ-003 Parameter NUM_RD, default 2: number of combinational read ports, legal range 1..4.
REQ-004 Parameter NUM_WR, default 1: number of write ports, legal range 1..2.
REQ-005 clk  input  1  single clock; all state changes on its rising edge; one clock, reset synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 wr_en  input  NUM_WR  per-port write enable.
REQ-008 wa  input  NUM_WR*ADDRESS_WIDTH  write addresses, port k at bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-009 wd  input  NUM_WR*D_WIDTH  write data, port k at bits [k*D_WIDTH +: D_WIDTH].
REQ-010 ra  input  NUM_RD*ADDRESS_WIDTH  read addresses, same packing as wa.
REQ-011 rd  output  NUM_RD*D_WIDTH  read data, same packing as wd.
REQ-012 ready  output  1  high when the clear sweep is complete and the file accepts writes.
REQ-013 wr_conflict  output  1  registered flag: both write ports targeted the same non-zero address in the previous cycle.

Function
REQ-014 The block SHALL implement a two-state FSM, CLEAR and READY, with a clear pointer of ADDRESS_WIDTH bits.
REQ-015 In CLEAR with rst low, each cycle SHALL zero entry ptr and increment ptr; after entry DEPTH-1 is zeroed, the next state SHALL be READY.
REQ-016 ready SHALL be 1 exactly in READY; after rst falls, ready rises DEPTH rising edges later.
REQ-017 In CLEAR, wr_en SHALL be ignored and every rd lane SHALL read 0.
REQ-018 In READY, an enabled write SHALL update the entry at wa on the rising edge; writes to address 0 SHALL be discarded.
REQ-019 Reads SHALL be combinational: rd lane j = entry[ra lane j]; address 0 SHALL always read 0.
REQ-020 When NUM_WR=2 and both ports write the same address in one cycle, port 1 data SHALL win.
REQ-021 wr_conflict SHALL be 1 in the cycle after a same-address, non-zero dual write in READY, else 0; tied 0 when NUM_WR=1.
REQ-022 Read lanes SHALL be independent; any number of lanes may address the same entry.

Reset
REQ-023 rst high at a rising edge SHALL force state CLEAR, ptr 0, wr_conflict 0, ready 0, regardless of current state.
REQ-024 rst asserted mid-sweep SHALL restart the sweep from entry 0; rst held high SHALL hold ptr at 0.
REQ-025 Entry contents SHALL not be guaranteed zero until ready=1.

Configuration
REQ-026 Macro REG_FILE_MP_BYPASS_EN SHALL control write-to-read forwarding.
REQ-027 With REG_FILE_MP_BYPASS_EN defined, in READY a read lane whose address matches an enabled non-zero write address in the same cycle SHALL return that write data (port 1 priority per REQ-020).
REQ-028 Without REG_FILE_MP_BYPASS_EN, reads SHALL return the stored value before the edge; new data is visible from the next cycle.

Verification (D_WIDTH=32, ADDRESS_WIDTH=5, NUM_RD=3, NUM_WR=2)
REQ-029 rst high 2 cycles, then low -> ready=0 for 32 edges, ready=1 after the 32nd edge; all ra in 0..31 read 0x00000000.
REQ-030 After ready, write port 0 addr 5 = 0xDEADBEEF, port 1 addr 0 = 0x12345678 -> next cycle ra=5 reads 0xDEADBEEF, ra=0 reads 0; wr_conflict=0.
REQ-031 Both ports write addr 7 (port 0 0x11111111, port 1 0x22222222) -> addr 7 reads 0x22222222; wr_conflict=1 for one cycle, then 0.
REQ-032 With REG_FILE_MP_BYPASS_EN: write addr 9 = 0xCAFEF00D while ra lane 2 = 9 -> lane 2 shows 0xCAFEF00D in the same cycle; without the macro, lane 2 shows the old value 0x00000000.
REQ-033 Assert rst at sweep cycle 10 for 1 cycle, with wr_en held high at addr 3 -> ready rises 32 edges after rst falls; addr 3 reads 0 after the sweep.
REQ-034 Three read lanes all at addr 5 plus lane reads of addr 31 after a write of 0xFFFFFFFF to addr 31 -> all lanes return the correct values simultaneously.
